lsu_multicycle: RTL
===================

Name: lsu_multicycle

Overview:
- Parametrised load/store unit for the multicycle RV core, sitting between the control FSM/datapath and the memory port.
- Accepts one load or store per handshake and drives word-aligned memory requests with byte enables.
- Waits for mem_resp, then returns sign/zero-extended load data or a store completion.
- Adds width generalisation, byte-enable generation, an access-timeout watchdog, and optional misaligned-access splitting.

Parameters:
- XLEN, 32, data/address width; legal values are 32 and 64.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles spent waiting for mem_resp; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  [1:0] size (0 = byte, 1 = half, 2 = word, 3 = double); [2] = unsigned, loads only.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size.
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_address  out  XLEN  aligned address; low log2(XLEN/8) bits are 0.
- mem_byte_enable  out  XLEN/8  active-high lane enables.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_rdata  in  XLEN  read data, valid with mem_resp.
- mem_resp  in  1  access complete.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; req_ready = 1.
  - rsp_valid, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata, rsp_rdata = 0; rsp_err = 00.
  - Reset mid-access drops strobes immediately and discards the pending request.
- States: IDLE, ACCESS, ACCESS2 (only with MISALIGNED_SPLIT_EN), RESP.
- req_ready = 1 only in IDLE. A request is accepted on req_valid & req_ready, and all request fields are registered at acceptance.
- Decode at acceptance (B = XLEN/8, off = req_addr mod B, n = 1 << size):
  - Illegal size: n > B. Go to RESP, err 11, no memory cycle.
  - Misaligned: off mod n != 0. Without the macro: go to RESP, err 01, no memory cycle.
  - Otherwise: go to ACCESS.
- ACCESS:
  - mem_read (load) or mem_write (store) held high every cycle, with stable address, byte enable and wdata, until mem_resp is sampled high.
  - mem_byte_enable = ((1 << n) - 1) << off, truncated to B bits.
  - mem_wdata = req_wdata << 8*off.
  - On mem_resp: strobes drop the next cycle. Loads capture mem_rdata. Next state is RESP, or ACCESS2 for a split access.
- Load extraction:
  - Take mem_rdata >> 8*off, keep the low 8n bits.
  - Sign-extend if funct3[2] = 0, zero-extend otherwise.
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE. rsp_valid has no backpressure.
- Latency: acceptance at cycle 0, strobe from cycle 1. With mem_resp in cycle 1, rsp_valid is in cycle 2. Error responses without a memory cycle give rsp_valid in cycle 1.
- mem_resp is ignored in IDLE and RESP.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP, so throughput is at most one request per 3 cycles.
- Watchdog:
  - Counter clears on entry to each ACCESS/ACCESS2 phase and increments each cycle without mem_resp.
  - When it reaches TIMEOUT_CYCLES: strobes drop, go to RESP with err 10, rsp_rdata = 0.
  - mem_resp in the same cycle as expiry wins, giving a normal completion.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: a misaligned legal access is split into two aligned accesses.
  - ACCESS covers lanes off..B-1 at addr & ~(B-1).
  - ACCESS2 covers the remaining n - (B - off) low lanes at (addr & ~(B-1)) + B, with wdata shifted right by 8*(B - off).
  - Load bytes from both beats are merged before extension.
  - The watchdog applies per phase; a timeout in either phase aborts with err 10.
  - Accesses that do not cross a B boundary, such as a half at off = 1, stay single-access with no error.
- Undefined: misaligned accesses respond err 01 as described above; the ACCESS2 state is absent.

Test Plan:
- XLEN = 32, LW at 0x100, mem_resp in cycle 1 with mem_rdata = 0xDEADBEEF -> mem_address 0x100, byte_enable 1111, rsp_valid in cycle 2, rdata 0xDEADBEEF, err 00.
- LB at 0x203, mem_rdata = 0x80FFFFFF -> byte_enable 1000, rdata 0xFFFFFF80. The same access as LBU -> rdata 0x00000080.
- SH at 0x102, wdata 0x1234ABCD -> mem_write, address 0x100, byte_enable 1100, mem_wdata 0xABCD0000.
- TIMEOUT_CYCLES = 4, LW with mem_resp never asserted -> mem_read high exactly 4 cycles, rsp_err 10, rdata 0.
- LW at 0x101:
  - Macro undefined -> no mem strobe, rsp_valid in cycle 1, err 01.
  - Macro defined, beats return 0x44332211 then 0x88776655 -> accesses 0x100 (byte_enable 1110) and 0x104 (byte_enable 0001), rdata 0x55443322.
- rst pulled low while mem_read is high in ACCESS -> mem_read is 0 immediately; after release req_ready = 1 and no rsp_valid is ever emitted for the aborted request.

Source files
------------

// File: rtl/lsu_multicycle.sv
// rtl/lsu_multicycle.sv - multicycle load/store unit with lane enables and access watchdog
// Optional misaligned-access splitting is enabled by defining LSU_MISALIGNED_SPLIT_EN.
module lsu_multicycle #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic [1:0]        rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [XLEN-1:0]   mem_address,
   output logic [XLEN/8-1:0] mem_byte_enable,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic [XLEN-1:0]   mem_rdata,
   input  logic              mem_resp
);
   localparam int B  = XLEN / 8;
   localparam int OW = $clog2(B);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
   localparam logic [CW-1:0] TLAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
`ifdef LSU_MISALIGNED_SPLIT_EN
   localparam int SPAN = 2;
`else
   localparam int SPAN = 1;
`endif

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
`ifdef LSU_MISALIGNED_SPLIT_EN
      , ACCESS2 = 2'd3
`endif
   } state_t;

   state_t          state;
   logic            r_store, r_uns;
   logic [1:0]      r_size;
   logic [OW-1:0]   r_off;
   logic [CW-1:0]   cnt;

   // Lanes/data are computed over two words so the upper half feeds a split second beat.
   function automatic logic [SPAN*B-1:0] lane_mask(input logic [1:0] size, input logic [OW-1:0] off);
      logic [SPAN*B-1:0] m;
      m = ((SPAN*B)'(1) << (1 << size)) - (SPAN*B)'(1);
      return m << off;
   endfunction

   function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d, input logic [1:0] size,
                                             input logic uns);
      logic [XLEN-1:0] mask, top;
      mask = {XLEN{1'b1}} >> (XLEN - (8 << size));
      top  = mask & ~(mask >> 1);
      if (!uns && (|(d & top)))
         return d | ~mask;
      return d & mask;
   endfunction

   logic [OW-1:0]        in_off;
   int                   in_n;
   logic                 illegal, misal, reject_misal;
   logic [SPAN*B-1:0]    in_lanes;
   logic [SPAN*XLEN-1:0] in_wd;
   logic [XLEN-1:0]      in_align, beat_data, ld_data;

   always_comb begin
      in_off    = req_addr[OW-1:0];
      in_n      = 1 << req_funct3[1:0];
      illegal   = in_n > B;
      misal     = (int'(in_off) & (in_n - 1)) != 0;
      in_lanes  = lane_mask(req_funct3[1:0], in_off);
      in_wd     = {{((SPAN-1)*XLEN){1'b0}}, req_wdata} << (8 * int'(in_off));
      in_align  = {req_addr[XLEN-1:OW], {OW{1'b0}}};
      beat_data = mem_rdata >> (8 * int'(r_off));
      ld_data   = extend(beat_data, r_size, r_uns);
   end

`ifdef LSU_MISALIGNED_SPLIT_EN
   logic            r_split, split;
   logic [XLEN-1:0] hi_address, hi_wd, lo_data, ld2_data;
   logic [B-1:0]    hi_be;

   assign split        = misal && (int'(in_off) + in_n > B);
   assign reject_misal = 1'b0;
   assign ld2_data     = extend(lo_data | (mem_rdata << (8 * (B - int'(r_off)))), r_size, r_uns);
`else
   assign reject_misal = misal;
`endif

   assign req_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         rsp_valid       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_err         <= 2'b00;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_address     <= '0;
         mem_byte_enable <= '0;
         mem_wdata       <= '0;
         r_store         <= 1'b0;
         r_uns           <= 1'b0;
         r_size          <= 2'd0;
         r_off           <= '0;
         cnt             <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
         r_split         <= 1'b0;
         hi_address      <= '0;
         hi_be           <= '0;
         hi_wd           <= '0;
         lo_data         <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               r_store <= req_store;
               r_size  <= req_funct3[1:0];
               r_uns   <= req_funct3[2];
               r_off   <= in_off;
               cnt     <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
               r_split    <= split;
               hi_address <= in_align + XLEN'(B);
               hi_be      <= in_lanes[2*B-1:B];
               hi_wd      <= in_wd[2*XLEN-1:XLEN];
`endif
               if (illegal || reject_misal) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= illegal ? 2'b11 : 2'b01;
                  rsp_rdata <= '0;
               end else begin
                  state           <= ACCESS;
                  mem_read        <= ~req_store;
                  mem_write       <= req_store;
                  mem_address     <= in_align;
                  mem_byte_enable <= in_lanes[B-1:0];
                  mem_wdata       <= in_wd[XLEN-1:0];
               end
            end
            ACCESS: begin
               if (mem_resp) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                  // Strobes stay up into the second beat; only the address/lanes move.
                  if (r_split) begin
                     state           <= ACCESS2;
                     cnt             <= '0;
                     lo_data         <= beat_data;
                     mem_address     <= hi_address;
                     mem_byte_enable <= hi_be;
                     mem_wdata       <= hi_wd;
                  end else
`endif
                  begin
                     state     <= RESP;
                     mem_read  <= 1'b0;
                     mem_write <= 1'b0;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 2'b00;
                     rsp_rdata <= r_store ? '0 : ld_data;
                  end
               end else if (TIMEOUT_CYCLES != 0 && cnt == TLAST) begin
                  state     <= RESP;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 2'b10;
                  rsp_rdata <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            ACCESS2: begin
               if (mem_resp || (TIMEOUT_CYCLES != 0 && cnt == TLAST)) begin
                  state     <= RESP;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= mem_resp ? 2'b00 : 2'b10;
                  rsp_rdata <= (mem_resp && !r_store) ? ld2_data : '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
`endif
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
